// File: rtl/aes_out_packer_if.sv
// Output bus of the AES plaintext packer: 512-bit words with a 4-lane keep mask.
// A word transfers on any rising clk where m_valid & m_ready; the master holds
// m_data/m_keep stable while m_valid is high and m_ready is low.
interface aes_out_packer_if;
  logic         m_valid;
  logic         m_ready;
  logic [511:0] m_data;
  logic [3:0]   m_keep;

  modport master (
    output m_valid,
    output m_data,
    output m_keep,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_keep,
    output m_ready
  );
endinterface

// File: rtl/aes_out_packer.sv
// Packs in-order 128-bit AES plaintext blocks into 512-bit words, buffers them in
// a show-ahead FIFO and drops (with a sticky flag) words that arrive while full.
module aes_out_packer #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_in_valid,
  input  logic [127:0]          data_in,
  input  logic                  flush,
  aes_out_packer_if.master      m_if,
  output logic [CNT_W-1:0]      level,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Assembly register
  logic [3:0][127:0] asm_q;
  logic [3:0][127:0] asm_next;
  logic [1:0]        lane_q;
  logic [3:0]        keep_q;
  logic [3:0]        keep_next;
  logic [511:0]      push_data;
  logic              push;

  // FIFO storage and control
  logic [511:0]      mem_data [FIFO_DEPTH];
  logic [3:0]        mem_keep [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              not_empty;
  logic              pop;
  logic              wr_en;

  // The current cycle's block is folded in before deciding on a push, so a
  // flush coinciding with the fourth block yields a single full word.
  always_comb begin
    asm_next  = asm_q;
    keep_next = keep_q;
    if (data_in_valid) begin
      asm_next[lane_q]  = data_in;
      keep_next[lane_q] = 1'b1;
    end
  end

  assign push = (data_in_valid && (lane_q == 2'd3)) || (flush && (keep_next != 4'b0000));

  // Unfilled lanes of a partial word go out as zero rather than stale data.
  always_comb begin
    push_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (keep_next[i]) begin
        push_data[128*i +: 128] = asm_next[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q  <= '0;
      lane_q <= 2'd0;
      keep_q <= 4'b0000;
    end else if (push) begin
      lane_q <= 2'd0;
      keep_q <= 4'b0000;
    end else if (data_in_valid) begin
      asm_q  <= asm_next;
      lane_q <= lane_q + 2'd1;
      keep_q <= keep_next;
    end
  end

  assign not_empty = (count != '0);
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign pop       = not_empty && m_if.m_ready;
  // A push into a full FIFO still lands if the head leaves on the same edge.
  assign wr_en     = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= push_data;
      mem_keep[wr_ptr] <= keep_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push && !wr_en) begin
        overflow <= 1'b1;
      end
    end
  end

  // Outputs derive only from registered state; gating by not_empty keeps the
  // bus at zero after reset without resetting the storage array.
  assign m_if.m_valid = not_empty;
  assign m_if.m_data  = not_empty ? mem_data[rd_ptr] : '0;
  assign m_if.m_keep  = not_empty ? mem_keep[rd_ptr] : 4'b0000;
  assign level        = count;

endmodule

// File: tb/tb_aes_out_packer.sv
// Directed bench for aes_out_packer: reset, packing, flush, overflow, full-with-pop
// and asynchronous reset scenarios with hand-computed expected words.
module tb_aes_out_packer;

  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             data_in_valid;
  logic [127:0]     data_in;
  logic             flush;
  logic [CNT_W-1:0] level;
  logic             overflow;

  int n_checks = 0;
  int n_errors = 0;

  aes_out_packer_if bus ();

  aes_out_packer #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in_valid (data_in_valid),
    .data_in       (data_in),
    .flush         (flush),
    .m_if          (bus),
    .level         (level),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] make_word(input int b);
    return {128'(b + 3), 128'(b + 2), 128'(b + 1), 128'(b)};
  endfunction

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_block(input logic [127:0] d, input logic fl);
    data_in_valid = 1'b1;
    data_in       = d;
    flush         = fl;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_cycle();
    idle_cycle();
    rst = 1'b1;
    idle_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.m_valid !== 1'b0) begin n_errors++; $display("FAIL reset_m_valid got %b expected 0", bus.m_valid); end
    repeat (2) idle_cycle();
    rst = 1'b1;
    repeat (2) idle_cycle();
    n_checks++;
    if (bus.m_valid !== 1'b0) begin n_errors++; $display("FAIL idle_m_valid got %b expected 0", bus.m_valid); end
    n_checks++;
    if (level !== '0) begin n_errors++; $display("FAIL idle_level got %0d expected 0", level); end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL idle_overflow got %b expected 0", overflow); end
    n_checks++;
    if (bus.m_data !== 512'b0) begin n_errors++; $display("FAIL idle_m_data got %h expected 0", bus.m_data); end
    n_checks++;
    if (bus.m_keep !== 4'b0) begin n_errors++; $display("FAIL idle_m_keep got %h expected 0", bus.m_keep); end
  endtask

  task automatic test_back_to_back();
    bus.m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive_block(128'(i), 1'b0);
      n_checks++;
      if (level > 1) begin n_errors++; $display("FAIL b2b_level got %0d expected <=1", level); end
      if (i == 4 || i == 8) begin
        n_checks++;
        if (bus.m_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_valid_w%0d got %b expected 1", i / 4, bus.m_valid); end
        n_checks++;
        if (bus.m_data !== make_word(i - 3)) begin
          n_errors++; $display("FAIL b2b_data_w%0d got %h expected %h", i / 4, bus.m_data, make_word(i - 3));
        end
        n_checks++;
        if (bus.m_keep !== 4'hF) begin n_errors++; $display("FAIL b2b_keep_w%0d got %h expected f", i / 4, bus.m_keep); end
      end
    end
    idle_cycle();
    n_checks++;
    if (bus.m_valid !== 1'b0 || level !== '0) begin
      n_errors++; $display("FAIL b2b_drained got valid=%b level=%0d expected valid=0 level=0", bus.m_valid, level);
    end
    bus.m_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic [127:0] a;
    logic [127:0] b;
    logic [511:0] e;
    a = 128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF;
    b = 128'hB0B1_B2B3_B4B5_B6B7_B8B9_BABB_BCBD_BEBF;
    e = '0;
    e[127:0]   = a;
    e[255:128] = b;
    bus.m_ready = 1'b0;
    drive_block(a, 1'b0);
    drive_block(b, 1'b0);
    n_checks++;
    if (bus.m_valid !== 1'b0) begin n_errors++; $display("FAIL flush_pre_valid got %b expected 0", bus.m_valid); end
    flush = 1'b1;
    idle_cycle();
    flush = 1'b0;
    n_checks++;
    if (bus.m_keep !== 4'b0011) begin n_errors++; $display("FAIL flush2_keep got %b expected 0011", bus.m_keep); end
    n_checks++;
    if (bus.m_data !== e) begin n_errors++; $display("FAIL flush2_data got %h expected %h", bus.m_data, e); end
    n_checks++;
    if (level !== CNT_W'(1)) begin n_errors++; $display("FAIL flush2_level got %0d expected 1", level); end
    bus.m_ready = 1'b1;
    idle_cycle();
    bus.m_ready = 1'b0;
    // three held blocks plus the fourth arriving with flush
    drive_block(128'(50), 1'b0);
    drive_block(128'(51), 1'b0);
    drive_block(128'(52), 1'b0);
    drive_block(128'(53), 1'b1);
    idle_cycle();
    n_checks++;
    if (level !== CNT_W'(1)) begin n_errors++; $display("FAIL flush4_level got %0d expected 1", level); end
    n_checks++;
    if (bus.m_keep !== 4'hF) begin n_errors++; $display("FAIL flush4_keep got %h expected f", bus.m_keep); end
    n_checks++;
    if (bus.m_data !== make_word(50)) begin n_errors++; $display("FAIL flush4_data got %h expected %h", bus.m_data, make_word(50)); end
    bus.m_ready = 1'b1;
    idle_cycle();
    bus.m_ready = 1'b0;
    flush = 1'b1;
    idle_cycle();
    flush = 1'b0;
    idle_cycle();
    n_checks++;
    if (bus.m_valid !== 1'b0 || level !== '0) begin
      n_errors++; $display("FAIL flush_empty got valid=%b level=%0d expected valid=0 level=0", bus.m_valid, level);
    end
  endtask

  task automatic test_overflow();
    logic [511:0] exp_q[$];
    logic [511:0] exp_w;
    bus.m_ready = 1'b0;
    for (int i = 0; i < 36; i++) begin
      drive_block(128'(100 + i), 1'b0);
      if (i % 4 == 3 && i < 32) exp_q.push_back(make_word(100 + i - 3));
      if (i == 31) begin
        n_checks++;
        if (level !== CNT_W'(8) || overflow !== 1'b0) begin
          n_errors++; $display("FAIL ovf_at_full got level=%0d ovf=%b expected level=8 ovf=0", level, overflow);
        end
      end
    end
    n_checks++;
    if (level !== CNT_W'(8)) begin n_errors++; $display("FAIL ovf_level got %0d expected 8", level); end
    n_checks++;
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_flag got %b expected 1", overflow); end
    for (int w = 0; w < 8; w++) begin
      exp_w = exp_q.pop_front();
      n_checks++;
      if (bus.m_valid !== 1'b1) begin n_errors++; $display("FAIL drain_valid_%0d got %b expected 1", w, bus.m_valid); end
      n_checks++;
      if (bus.m_data !== exp_w) begin n_errors++; $display("FAIL drain_data_%0d got %h expected %h", w, bus.m_data, exp_w); end
      idle_cycle();
      n_checks++;
      if (bus.m_data !== exp_w || bus.m_keep !== 4'hF) begin
        n_errors++; $display("FAIL drain_stall_%0d got %h keep %h expected %h keep f", w, bus.m_data, bus.m_keep, exp_w);
      end
      bus.m_ready = 1'b1;
      idle_cycle();
      bus.m_ready = 1'b0;
    end
    n_checks++;
    if (bus.m_valid !== 1'b0 || level !== '0) begin
      n_errors++; $display("FAIL drain_end got valid=%b level=%0d expected valid=0 level=0", bus.m_valid, level);
    end
    n_checks++;
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky got %b expected 1", overflow); end
  endtask

  task automatic test_full_pop();
    do_reset();
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL fp_ovf_cleared got %b expected 0", overflow); end
    bus.m_ready = 1'b0;
    for (int i = 0; i < 35; i++) drive_block(128'(200 + i), 1'b0);
    n_checks++;
    if (level !== CNT_W'(8)) begin n_errors++; $display("FAIL fp_level_pre got %0d expected 8", level); end
    bus.m_ready = 1'b1;
    drive_block(128'(235), 1'b0);
    bus.m_ready = 1'b0;
    n_checks++;
    if (level !== CNT_W'(8)) begin n_errors++; $display("FAIL fp_level got %0d expected 8", level); end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL fp_ovf got %b expected 0", overflow); end
    n_checks++;
    if (bus.m_data !== make_word(204)) begin n_errors++; $display("FAIL fp_head got %h expected %h", bus.m_data, make_word(204)); end
    bus.m_ready = 1'b1;
    repeat (7) idle_cycle();
    n_checks++;
    if (bus.m_data !== make_word(232)) begin n_errors++; $display("FAIL fp_last got %h expected %h", bus.m_data, make_word(232)); end
    idle_cycle();
    bus.m_ready = 1'b0;
    n_checks++;
    if (level !== '0) begin n_errors++; $display("FAIL fp_drained got %0d expected 0", level); end
  endtask

  task automatic test_async_reset();
    bus.m_ready = 1'b0;
    for (int i = 0; i < 14; i++) drive_block(128'(300 + i), 1'b0);
    n_checks++;
    if (level !== CNT_W'(3)) begin n_errors++; $display("FAIL ar_level_pre got %0d expected 3", level); end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.m_valid !== 1'b0 || level !== '0 || overflow !== 1'b0) begin
      n_errors++; $display("FAIL ar_immediate got valid=%b level=%0d ovf=%b expected 0/0/0", bus.m_valid, level, overflow);
    end
    n_checks++;
    if (bus.m_data !== 512'b0 || bus.m_keep !== 4'b0) begin
      n_errors++; $display("FAIL ar_bus got %h keep %h expected 0", bus.m_data, bus.m_keep);
    end
    repeat (2) idle_cycle();
    rst = 1'b1;
    repeat (2) idle_cycle();
    n_checks++;
    if (bus.m_valid !== 1'b0) begin n_errors++; $display("FAIL ar_quiet got %b expected 0", bus.m_valid); end
    for (int i = 0; i < 4; i++) drive_block(128'(400 + i), 1'b0);
    n_checks++;
    if (bus.m_data !== make_word(400) || bus.m_keep !== 4'hF) begin
      n_errors++; $display("FAIL ar_clean_word got %h keep %h expected %h keep f", bus.m_data, bus.m_keep, make_word(400));
    end
    n_checks++;
    if (level !== CNT_W'(1)) begin n_errors++; $display("FAIL ar_level got %0d expected 1", level); end
  endtask

  initial begin
    rst           = 1'b0;
    data_in_valid = 1'b0;
    data_in       = '0;
    flush         = 1'b0;
    bus.m_ready   = 1'b0;
    test_reset();
    test_back_to_back();
    test_flush();
    test_overflow();
    test_full_pop();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
